// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller and its timers.
package elevator_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DOOR = 2'd3
    } state_t;

    // Direction of the most recent move; UP is the reset preference.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Counter width able to hold 0 .. max(travel, door)-1.
    function automatic int cnt_width(input int travel_cycles, input int door_cycles);
        int max_cycles;
        max_cycles = (travel_cycles > door_cycles) ? travel_cycles : door_cycles;
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

    // Width for the default 50M travel / 100M door timing.
    localparam int CNT_W_DEFAULT = cnt_width(50000000, 100000000);

endpackage

// File: rtl/elevator_timer.sv
// Wrapping cycle counter: counts 0..LIMIT-1 while enabled, flags the last count.
module elevator_timer
    import elevator_pkg::*;
#(
    parameter int WIDTH = CNT_W_DEFAULT,
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    // Terminal count decoded from the count register.
    always_comb begin
        o_tc = (r_count == LAST_COUNT);
    end

    // Count register: clear has priority, wrap to zero after the last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (o_tc) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator controller: latches floor calls, moves the car one floor per
// TRAVEL_CYCLES and opens the door for DOOR_CYCLES at each requested floor.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 10,
    parameter int TRAVEL_CYCLES = 50000000,
    parameter int DOOR_CYCLES   = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [3:0]            floor_bcd,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int         CNT_W      = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam logic [3:0] TOP_FLOOR  = 4'(NUM_FLOORS - 1);

    state_t                r_state;
    state_t                w_next_state;
    dir_t                  r_last_dir;
    logic [3:0]            r_floor;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] w_pending_next;
    logic                  r_stepped;
    logic                  r_moving_up;
    logic                  r_moving_down;
    logic                  r_door_open;
    logic                  w_any_above;
    logic                  w_any_below;
    logic                  w_here;
    logic                  w_moving;
    logic                  w_in_door;
    logic                  w_travel_tc;
    logic                  w_door_tc;

    assign w_moving  = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign w_in_door = (r_state == ST_DOOR);

    // Travel timer runs only while moving and restarts from zero on every move.
    elevator_timer #(
        .WIDTH (CNT_W),
        .LIMIT (TRAVEL_CYCLES)
    ) u_travel_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_moving),
        .i_enable (w_moving),
        .o_tc     (w_travel_tc)
    );

    // Door timer runs only while the door is open.
    elevator_timer #(
        .WIDTH (CNT_W),
        .LIMIT (DOOR_CYCLES)
    ) u_door_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (!w_in_door),
        .i_enable (w_in_door),
        .o_tc     (w_door_tc)
    );

    // Classify latched requests relative to the current floor.
    always_comb begin
        w_any_above = 1'b0;
        w_any_below = 1'b0;
        w_here      = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (4'(i) > r_floor) begin
                w_any_above = w_any_above | r_pending[i];
            end else if (4'(i) < r_floor) begin
                w_any_below = w_any_below | r_pending[i];
            end else begin
                w_here = w_here | r_pending[i];
            end
        end
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_here) begin
                    w_next_state = ST_DOOR;
                end else if (w_any_above && w_any_below) begin
                    w_next_state = (r_last_dir == DIR_UP) ? ST_UP : ST_DOWN;
                end else if (w_any_above) begin
                    w_next_state = ST_UP;
                end else if (w_any_below) begin
                    w_next_state = ST_DOWN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_UP: begin
                // Arrival decisions are taken the cycle after a floor step.
                if (r_stepped) begin
                    if (w_here) begin
                        w_next_state = ST_DOOR;
                    end else if (w_any_above) begin
                        w_next_state = ST_UP;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_UP;
                end
            end
            ST_DOWN: begin
                if (r_stepped) begin
                    if (w_here) begin
                        w_next_state = ST_DOOR;
                    end else if (w_any_below) begin
                        w_next_state = ST_DOWN;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_DOWN;
                end
            end
            ST_DOOR: begin
                // On closing, keep the last direction if it still has work.
                if (w_door_tc) begin
                    if (r_last_dir == DIR_UP) begin
                        if (w_any_above) begin
                            w_next_state = ST_UP;
                        end else if (w_any_below) begin
                            w_next_state = ST_DOWN;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end else begin
                        if (w_any_below) begin
                            w_next_state = ST_DOWN;
                        end else if (w_any_above) begin
                            w_next_state = ST_UP;
                        end else begin
                            w_next_state = ST_IDLE;
                        end
                    end
                end else begin
                    w_next_state = ST_DOOR;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Request latch update: calls for the floor with the open door are
    // dropped, and the floor being opened is cleared (clear beats set).
    always_comb begin
        w_pending_next = r_pending;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (call_req[i] && !(w_in_door && (4'(i) == r_floor))) begin
                w_pending_next[i] = 1'b1;
            end else begin
                w_pending_next[i] = r_pending[i];
            end
            if ((w_next_state == ST_DOOR) && !w_in_door && (4'(i) == r_floor)) begin
                w_pending_next[i] = 1'b0;
            end else begin
                w_pending_next[i] = w_pending_next[i];
            end
        end
    end

    // State, request latch and arrival flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_stepped <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_stepped <= w_moving & w_travel_tc;
        end
    end

    // Floor position, stepped at the end of each travel interval and kept in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_floor <= 4'd0;
        end else if (w_travel_tc && (r_state == ST_UP) && (r_floor < TOP_FLOOR)) begin
            r_floor <= r_floor + 4'd1;
        end else if (w_travel_tc && (r_state == ST_DOWN) && (r_floor != 4'd0)) begin
            r_floor <= r_floor - 4'd1;
        end else begin
            r_floor <= r_floor;
        end
    end

    // Remember the direction of the latest move for tie-breaking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dir <= DIR_UP;
        end else if (w_next_state == ST_UP) begin
            r_last_dir <= DIR_UP;
        end else if (w_next_state == ST_DOWN) begin
            r_last_dir <= DIR_DOWN;
        end else begin
            r_last_dir <= r_last_dir;
        end
    end

    // Status outputs registered from the next state so they track r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_moving_up   <= 1'b0;
            r_moving_down <= 1'b0;
            r_door_open   <= 1'b0;
        end else begin
            r_moving_up   <= (w_next_state == ST_UP);
            r_moving_down <= (w_next_state == ST_DOWN);
            r_door_open   <= (w_next_state == ST_DOOR);
        end
    end

    assign floor_bcd   = r_floor;
    assign pending     = r_pending;
    assign moving_up   = r_moving_up;
    assign moving_down = r_moving_down;
    assign door_open   = r_door_open;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: expected output changes (floor and
// status with their cycle of appearance) are queued when calls are issued
// and popped whenever the observed outputs change.
module tb_elevator_ctrl;

    localparam int NF = 10;
    localparam int TC = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NF-1:0] call_req;
    logic [3:0]    floor_bcd;
    logic          moving_up;
    logic          moving_down;
    logic          door_open;
    logic [NF-1:0] pending;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [6:0] st;
    } ev_t;

    ev_t        exp_q[$];
    logic [6:0] prev_st;
    logic [6:0] obs_st;
    ev_t        ev;
    bit         mon_en = 1'b0;

    elevator_ctrl #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (TC),
        .DOOR_CYCLES   (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .call_req    (call_req),
        .floor_bcd   (floor_bcd),
        .moving_up   (moving_up),
        .moving_down (moving_down),
        .door_open   (door_open),
        .pending     (pending)
    );

    always #5 clk = ~clk;

    // Cycle stamp: number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] pack(input logic [3:0] f, input logic u, input logic d,
                                        input logic o);
        return {f, u, d, o};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int c, input int f, input logic u, input logic d, input logic o);
        ev_t e;
        e.cyc = c;
        e.st  = pack(4'(f), u, d, o);
        exp_q.push_back(e);
    endtask

    // Expected events of a move from 'from' to 'to' starting at cycle 'start'.
    task automatic push_trip(input int from, input int to, input int start, output int door_c);
        int   d;
        logic up;
        up = (to > from);
        d  = up ? (to - from) : (from - to);
        push_ev(start, from, up, !up, 1'b0);
        for (int k = 1; k <= d; k++) begin
            push_ev(start + k * TC, up ? (from + k) : (from - k), up, !up, 1'b0);
        end
        door_c = start + d * TC + 1;
        push_ev(door_c, to, 1'b0, 1'b0, 1'b1);
    endtask

    // One-cycle call pulse; returns the cycle in which it is latched.
    task automatic pulse_call(input logic [NF-1:0] bits, output int latch);
        call_req = bits;
        latch    = cyc + 1;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int extra);
        int guard;
        guard = 0;
        while ((exp_q.size() > 0) && (guard < 500)) begin
            @(negedge clk);
            guard++;
        end
        repeat (extra) @(negedge clk);
        check_val("drain", exp_q.size(), 0);
    endtask

    // Monitor: every change of floor/status must match the next queued event.
    always @(negedge clk) begin
        if (mon_en) begin
            obs_st = pack(floor_bcd, moving_up, moving_down, door_open);
            if (obs_st !== prev_st) begin
                if (exp_q.size() > 0) begin
                    ev = exp_q.pop_front();
                    check_val("ev_state", obs_st, ev.st);
                    check_val("ev_cycle", cyc, ev.cyc);
                end else begin
                    check_val("spurious_change", obs_st, prev_st);
                end
                prev_st = obs_st;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int l;
        int l2;
        int s;
        int dc;
        int dc2;

        rst      = 1'b1;
        call_req = '0;
        repeat (3) @(negedge clk);
        check_val("rst_floor", floor_bcd, 0);
        check_val("rst_status", {moving_up, moving_down, door_open}, 0);
        check_val("rst_pending", pending, 0);
        prev_st = 7'd0;
        mon_en  = 1'b1;
        rst     = 1'b0;
        @(negedge clk);

        // Call at the current floor: door opens one cycle after the latch.
        pulse_call(10'b1, l);
        check_val("s1_pend_set", pending, 10'b1);
        push_ev(l + 1, 0, 1'b0, 1'b0, 1'b1);
        push_ev(l + 1 + DC, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("s1_pend_clr", pending, 0);
        check_val("s1_door", door_open, 1);
        drain(2);

        // Floor 0 to 3.
        pulse_call(10'b1 << 3, l);
        check_val("s2_pend_set", pending, 10'b1 << 3);
        push_trip(0, 3, l + 1, dc);
        push_ev(dc + DC, 3, 1'b0, 1'b0, 1'b0);
        drain(2);
        check_val("s2_floor", floor_bcd, 3);

        // Up to 7; a call for 2 arrives at floor 5, served after 7.
        pulse_call(10'b1 << 7, l);
        s = l + 1;
        push_trip(3, 7, s, dc);
        wait_cyc(s + 9);
        check_val("s3_floor5", floor_bcd, 5);
        pulse_call(10'b1 << 2, l2);
        check_val("s3_pend_both", pending, (10'b1 << 7) | (10'b1 << 2));
        push_trip(7, 2, dc + DC, dc2);
        push_ev(dc2 + DC, 2, 1'b0, 1'b0, 1'b0);
        drain(2);
        check_val("s3_pend_empty", pending, 0);

        // Call for floor 4 while its door is open is ignored.
        pulse_call(10'b1 << 4, l);
        push_trip(2, 4, l + 1, dc);
        push_ev(dc + DC, 4, 1'b0, 1'b0, 1'b0);
        wait_cyc(dc);
        check_val("s4_door", door_open, 1);
        pulse_call(10'b1 << 4, l2);
        check_val("s4_ignore_a", pending, 0);
        @(negedge clk);
        check_val("s4_ignore_b", pending, 0);
        drain(6);

        // Reset at floor 4 while idle.
        rst = 1'b1;
        push_ev(cyc + 1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_val("s5_rst_floor", floor_bcd, 0);

        // Reset mid-move between floors 2 and 3 discards everything.
        pulse_call((10'b1 << 5) | (10'b1 << 8), l);
        check_val("s5_pend_set", pending, (10'b1 << 5) | (10'b1 << 8));
        s = l + 1;
        push_ev(s, 0, 1'b1, 1'b0, 1'b0);
        push_ev(s + TC, 1, 1'b1, 1'b0, 1'b0);
        push_ev(s + 2 * TC, 2, 1'b1, 1'b0, 1'b0);
        wait_cyc(s + 10);
        rst      = 1'b1;
        call_req = 10'b1 << 7;
        push_ev(s + 11, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst      = 1'b0;
        call_req = '0;
        check_val("s5_mid_floor", floor_bcd, 0);
        check_val("s5_mid_pending", pending, 0);
        check_val("s5_mid_status", {moving_up, moving_down, door_open}, 0);
        repeat (20) @(negedge clk);
        check_val("s5_still_idle", pending, 0);
        drain(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/elevator_ctrl.md
ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- NUM_FLOORS, 10, floors served, range 2..10; floors 0..NUM_FLOORS-1.
- TRAVEL_CYCLES, 50000000, clocks per one-floor move, >=2.
- DOOR_CYCLES, 100000000, clocks door stays open, >=2.

REQ-002 Ports (name, direction, width, meaning); one clock; reset is synchronous and active-high:
- clk, in, 1, sole clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- call_req, in, NUM_FLOORS, per-floor call; bit i high for >=1 cycle requests floor i.
- floor_bcd, out, 4, current floor in BCD, 0..NUM_FLOORS-1; drives the BCD-to-7-segment decoder directly.
- moving_up, out, 1, high in state UP.
- moving_down, out, 1, high in state DOWN.
- door_open, out, 1, high in state DOOR.
- pending, out, NUM_FLOORS, latched unserved requests.

Function
REQ-003 FSM states: IDLE, UP, DOWN, DOOR; outputs registered and decoded from state.
REQ-004 pending[i] SHALL set the cycle after call_req[i] is high, and clear on the cycle DOOR is entered at floor i.
REQ-005 call_req for the current floor while in DOOR SHALL be ignored (not latched).
REQ-006 Set and clear of the same bit in the same cycle: clear wins.
REQ-007 IDLE: pending[floor] set -> DOOR next cycle; else requests only above -> UP; only below -> DOWN; both -> direction of last move (UP after reset); none -> stay IDLE.
REQ-008 UP/DOWN: travel counter clears on state entry and increments each cycle; on count TRAVEL_CYCLES-1, floor_bcd SHALL step +1 (UP) or -1 (DOWN) and counter clears.
REQ-009 After a step, pending at new floor -> DOOR next cycle; else continue same direction.
REQ-010 floor_bcd SHALL never leave 0..NUM_FLOORS-1; UP is entered only with a request above, DOWN only with a request below.
REQ-011 DOOR lasts exactly DOOR_CYCLES cycles, then: pending in last direction -> that direction; else pending opposite -> opposite; else IDLE.
REQ-012 Latency: IDLE with single request at floor f, distance d -> DOOR entered 1 + d*TRAVEL_CYCLES + 1 cycles after request latched (d=0: 1 cycle).
REQ-013 Exactly one of moving_up, moving_down, door_open high, or none (IDLE); never two.

Reset
REQ-014 rst high at a clock edge SHALL force, next cycle: state IDLE, floor_bcd 0, pending 0, counters 0, last direction UP, all status outputs 0.
REQ-015 Reset mid-move or mid-door SHALL abandon the operation and discard all pending requests; call_req during reset is ignored.

Structure
REQ-016 Shared package elevator_pkg SHALL hold the state enum, last-direction encoding, and the counter-width constant derived from max(TRAVEL_CYCLES, DOOR_CYCLES).
REQ-017 One sub-module, elevator_timer (clear, enable, terminal-count output), SHALL implement the travel and door counters (two instances).

Verification (bench: NUM_FLOORS=10, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-018 Reset then call_req[0] one cycle -> door_open high 1 cycle after latch, for 3 cycles; pending[0] cleared; floor_bcd 0.
REQ-019 From floor 0, call_req[3] -> moving_up; floor_bcd 1,2,3 at 4-cycle spacing; door_open at 3; then IDLE.
REQ-020 At floor 5 moving up with pending {7,2} -> serves 7 first, then DOWN to 2; floor_bcd sequence 6,7,(door),6,5,4,3,2,(door).
REQ-021 call_req[4] while in DOOR at floor 4 -> pending[4] stays 0; door closes after 3 cycles, no reopen.
REQ-022 rst asserted while moving between floors 2 and 3 -> next cycle floor_bcd 0, pending 0, all status outputs 0.
